vbs_sad_min_pipe: RTL
=====================

VBS_SAD_MIN_PIPE -- requirements
Module: vbs_sad_min_pipe

Interface
REQ-001 The block SHALL have parameter PIX_WIDTH, default 8, width of one absolute-difference sample.
REQ-002 The block SHALL have parameter SAD_WIDTH, default PIX_WIDTH+8, width of every partition SAD; values below PIX_WIDTH+8 are illegal.
REQ-003 The block SHALL have parameter MV_WIDTH, default 6, width of each motion-vector component.
REQ-004 The block SHALL have one clock and an asynchronous active-low reset.
- clk  in  1  rising-edge clock
- rst_n  in  1  async reset, active low
- in_valid  in  1  candidate present this cycle
- in_first  in  1  first candidate of a search; qualified by in_valid
- in_last  in  1  last candidate of a search; qualified by in_valid
- in_mvx, in_mvy  in  MV_WIDTH each  signed candidate vector
- abs_diff[0:15][0:15]  in  PIX_WIDTH each  |cur-ref|, indexed [y][x]
- best_sad  out  41*SAD_WIDTH  packed per-partition minimum SAD
- best_mvx, best_mvy  out  41*MV_WIDTH each  vector of each minimum
- done  out  1  one-cycle pulse, results final
- busy  out  1  any valid in flight or search open

Function
REQ-005 Partition index order SHALL be: 0-15 4x4 (4*row+col), 16-23 8x4 (16+2*row+col), 24-31 4x8 (24+4*row+col), 32-35 8x8 (32+2*row+col), 36-37 16x8 (top, bottom), 38-39 8x16 (left, right), 40 16x16; partition WxH is W columns by H rows.
REQ-006 Stage 1 SHALL register sixteen 4x4 sums; stage 2 SHALL register 8x4, 4x8 and 8x8 sums; stage 3 SHALL register 16x8, 8x16 and 16x16 sums; stage 4 SHALL update best registers.
REQ-007 Every sum SHALL be zero-extended to SAD_WIDTH and never overflow or wrap.
REQ-008 in_valid, in_first, in_last and the vector SHALL travel with their data; the block SHALL accept one candidate per cycle with no backpressure.
REQ-009 A candidate entering at cycle t SHALL update best registers at the edge ending cycle t+3; outputs reflect it from cycle t+4.
REQ-010 For a candidate flagged in_first, each partition SHALL load its SAD and vector unconditionally.
REQ-011 Otherwise each partition SHALL replace its best only if new SAD is strictly less than stored; ties keep the earlier candidate.
REQ-012 done SHALL pulse in cycle t+4 for a candidate flagged in_last, coincident with final outputs.
REQ-013 in_first and in_last together SHALL form a one-candidate search with done at t+4.
REQ-014 Candidates between a last and the next first SHALL still flow through the pipeline but SHALL NOT change best registers or assert done.
REQ-015 A new in_first while a search is open SHALL restart the search from that candidate without asserting done.
REQ-016 best_* SHALL hold their values after done until the next in_first candidate reaches stage 4.
REQ-017 busy SHALL be high while any pipeline stage holds a valid candidate or a search is open, else low.

Reset
REQ-018 rst_n low SHALL asynchronously clear all pipeline valid bits, done and busy to 0.
REQ-019 rst_n low SHALL set every best_sad entry to all-ones and every best vector to 0.
REQ-020 Reset during a search SHALL discard in-flight candidates; no done SHALL follow until a new in_first/in_last pair.

Configuration
REQ-021 With SAD_SUBPART_EN defined, all 41 partitions SHALL be summed and tracked per REQ-005 to REQ-016.
REQ-022 Without SAD_SUBPART_EN, only index 40 (16x16) SHALL be tracked; entries 0-39 SHALL read 0 for SAD and vectors, and latency and done timing SHALL be unchanged.

Verification
REQ-023 All abs_diff=1, first+last, mv (3,-2) -> done at t+4; 4x4=16, 8x4/4x8=32, 8x8=64, 16x8/8x16=128, 16x16=256; all vectors (3,-2).
REQ-024 All abs_diff=255, PIX_WIDTH=8 -> 16x16=65280 with no wrap at SAD_WIDTH=16.
REQ-025 Three back-to-back candidates with uniform abs_diff 5, 2, 2 (mv 0,1,2) -> every partition best = mv 1 (tie keeps earlier); done only after third.
REQ-026 Only abs_diff[0][0]=9 on candidate A, all else 0; candidate B all 1 -> index 0 keeps A (9<16); indices 1-15 keep A (0); 16x16 keeps A (9<256).
REQ-027 Assert rst_n low one cycle after an in_last candidate -> no done; best_sad all-ones, busy 0.
REQ-028 Build without SAD_SUBPART_EN, run REQ-023 stimulus -> index 40=256, indices 0-39 read 0, done at t+4.

Source files
------------

// File: rtl/vbs_sad_min_pipe_if.sv
// rtl/vbs_sad_min_pipe_if.sv - candidate/result bundle for the variable-block-size SAD minimum search
interface vbs_sad_min_pipe_if #(
    parameter int PIX_WIDTH = 8,
    parameter int SAD_WIDTH = PIX_WIDTH + 8,
    parameter int MV_WIDTH  = 6
);
    logic                             in_valid;
    logic                             in_first;
    logic                             in_last;
    logic signed [MV_WIDTH-1:0]       in_mvx;
    logic signed [MV_WIDTH-1:0]       in_mvy;
    logic [0:15][0:15][PIX_WIDTH-1:0] abs_diff;
    logic [41*SAD_WIDTH-1:0]          best_sad;
    logic [41*MV_WIDTH-1:0]           best_mvx;
    logic [41*MV_WIDTH-1:0]           best_mvy;
    logic                             done;
    logic                             busy;

    modport master (
        output in_valid, in_first, in_last, in_mvx, in_mvy, abs_diff,
        input  best_sad, best_mvx, best_mvy, done, busy
    );

    modport slave (
        input  in_valid, in_first, in_last, in_mvx, in_mvy, abs_diff,
        output best_sad, best_mvx, best_mvy, done, busy
    );
endinterface

// File: rtl/vbs_sad_min_pipe.sv
// rtl/vbs_sad_min_pipe.sv - 4-stage 41-partition SAD minimum tracker
// SAD_SUBPART_EN tracks all 41 partitions; otherwise only the 16x16 (index 40).
module vbs_sad_min_pipe #(
    parameter int PIX_WIDTH = 8,
    parameter int SAD_WIDTH = PIX_WIDTH + 8,
    parameter int MV_WIDTH  = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    vbs_sad_min_pipe_if.slave bus
);
`ifdef SAD_SUBPART_EN
    localparam int FIRST = 0;
    localparam int P2LO  = 0;
`else
    localparam int FIRST = 40;
    localparam int P2LO  = 32;
`endif

    typedef logic [SAD_WIDTH-1:0] sad_t;
    typedef logic [MV_WIDTH-1:0]  mv_t;
    typedef enum logic {S_IDLE, S_OPEN} state_t;

    sad_t   w_p1 [16];
    sad_t   r_p1 [16];
    sad_t   w_p2 [P2LO:35];
    sad_t   r_p2 [P2LO:35];
    sad_t   w_p3 [FIRST:40];
    sad_t   r_p3 [FIRST:40];
    logic [3:1] r_v, r_f, r_l;
    mv_t    r_mvx [1:3];
    mv_t    r_mvy [1:3];
    sad_t   r_best_sad [FIRST:40];
    mv_t    r_best_mvx [FIRST:40];
    mv_t    r_best_mvy [FIRST:40];
    state_t r_state, w_state_nxt;
    logic   w_take, w_load, w_done_nxt, r_done;

    always_comb begin
        for (int b = 0; b < 16; b++) begin
            sad_t acc;
            acc = '0;
            for (int y = 0; y < 4; y++) begin
                for (int x = 0; x < 4; x++) begin
                    acc = acc + sad_t'(bus.abs_diff[4*(b/4)+y][4*(b%4)+x]);
                end
            end
            w_p1[b] = acc;
        end
    end

    // Stage 2 builds 8x4, 4x8 and 8x8 from the sixteen 4x4 sums; 4x4 ride along
    for (genvar i = P2LO; i < 36; i++) begin : g_p2
        if (i < 16) begin : g_44
            assign w_p2[i] = r_p1[i];
        end else if (i < 24) begin : g_84
            localparam int R = (i - 16) / 2;
            localparam int C = (i - 16) % 2;
            assign w_p2[i] = r_p1[4*R+2*C] + r_p1[4*R+2*C+1];
        end else if (i < 32) begin : g_48
            localparam int R = (i - 24) / 4;
            localparam int C = (i - 24) % 4;
            assign w_p2[i] = r_p1[8*R+C] + r_p1[8*R+C+4];
        end else begin : g_88
            localparam int R = (i - 32) / 2;
            localparam int C = (i - 32) % 2;
            assign w_p2[i] = r_p1[8*R+2*C] + r_p1[8*R+2*C+1]
                           + r_p1[8*R+2*C+4] + r_p1[8*R+2*C+5];
        end
    end

    for (genvar i = FIRST; i <= 40; i++) begin : g_p3
        if (i < 36) begin : g_pass
            assign w_p3[i] = r_p2[i];
        end else if (i < 38) begin : g_168
            assign w_p3[i] = r_p2[32+2*(i-36)] + r_p2[33+2*(i-36)];
        end else if (i < 40) begin : g_816
            assign w_p3[i] = r_p2[32+(i-38)] + r_p2[34+(i-38)];
        end else begin : g_1616
            assign w_p3[i] = r_p2[32] + r_p2[33] + r_p2[34] + r_p2[35];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v <= '0;
            r_f <= '0;
            r_l <= '0;
            for (int k = 1; k <= 3; k++) begin
                r_mvx[k] <= '0;
                r_mvy[k] <= '0;
            end
            for (int k = 0; k < 16; k++) r_p1[k] <= '0;
            for (int k = P2LO; k <= 35; k++) r_p2[k] <= '0;
            for (int k = FIRST; k <= 40; k++) r_p3[k] <= '0;
        end else begin
            r_v      <= {r_v[2:1], bus.in_valid};
            r_f      <= {r_f[2:1], bus.in_valid & bus.in_first};
            r_l      <= {r_l[2:1], bus.in_valid & bus.in_last};
            r_mvx[1] <= bus.in_mvx;
            r_mvy[1] <= bus.in_mvy;
            r_mvx[2] <= r_mvx[1];
            r_mvy[2] <= r_mvy[1];
            r_mvx[3] <= r_mvx[2];
            r_mvy[3] <= r_mvy[2];
            r_p1     <= w_p1;
            r_p2     <= w_p2;
            r_p3     <= w_p3;
        end
    end

    // A first always restarts the search; other candidates count only while a search is open
    always_comb begin
        w_state_nxt = r_state;
        w_take      = 1'b0;
        w_load      = 1'b0;
        w_done_nxt  = 1'b0;
        if (r_v[3]) begin
            if (r_f[3]) begin
                w_take      = 1'b1;
                w_load      = 1'b1;
                w_done_nxt  = r_l[3];
                w_state_nxt = r_l[3] ? S_IDLE : S_OPEN;
            end else if (r_state == S_OPEN) begin
                w_take = 1'b1;
                if (r_l[3]) begin
                    w_done_nxt  = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= w_done_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = FIRST; k <= 40; k++) begin
                r_best_sad[k] <= '1;
                r_best_mvx[k] <= '0;
                r_best_mvy[k] <= '0;
            end
        end else if (w_take) begin
            for (int k = FIRST; k <= 40; k++) begin
                if (w_load || (r_p3[k] < r_best_sad[k])) begin
                    r_best_sad[k] <= r_p3[k];
                    r_best_mvx[k] <= r_mvx[3];
                    r_best_mvy[k] <= r_mvy[3];
                end
            end
        end
    end

    always_comb begin
        bus.best_sad = '0;
        bus.best_mvx = '0;
        bus.best_mvy = '0;
        for (int k = FIRST; k <= 40; k++) begin
            bus.best_sad[k*SAD_WIDTH +: SAD_WIDTH] = r_best_sad[k];
            bus.best_mvx[k*MV_WIDTH +: MV_WIDTH]   = r_best_mvx[k];
            bus.best_mvy[k*MV_WIDTH +: MV_WIDTH]   = r_best_mvy[k];
        end
    end

    assign bus.done = r_done;
    assign bus.busy = (|r_v) || (r_state == S_OPEN);
endmodule
